// File: rtl/fetch_defs_pkg.sv
// Shared fetch-path definitions used by IF_Stage, the fetch queue and its testbench.
package fetch_defs_pkg;

    localparam int WORD_W            = 32;
    localparam int FETCH_QUEUE_DEPTH = 4;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instruction;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_ram.sv
// Fetch queue storage: DEPTH x DATA_W register array, one write port, one asynchronous read port.
module fetch_queue_ram #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic [DATA_W-1:0]        rd_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Storage array: cleared on reset so the head reads zero out of reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/if_fetch_queue.sv
// IF->ID fetch queue: buffers {pc, instruction}, freezes IF when full, flushes on branch_taken.
// Optional same-cycle IF->ID bypass when empty is enabled by defining FETCH_QUEUE_BYPASS_EN.
module if_fetch_queue #(
    parameter int DEPTH  = fetch_defs_pkg::FETCH_QUEUE_DEPTH,
    parameter int WORD_W = fetch_defs_pkg::WORD_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [WORD_W-1:0]        if_pc,
    input  logic [WORD_W-1:0]        if_instruction,
    output logic                     if_freeze,
    output logic                     id_valid,
    output logic [WORD_W-1:0]        id_pc,
    output logic [WORD_W-1:0]        id_instruction,
    input  logic                     id_ready,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};

    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                push_s;
    logic                bypass_s;
    logic                ram_pop_s;
    logic                wr_en_s;
    logic [2*WORD_W-1:0] rd_data_s;

    fetch_queue_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (2*WORD_W)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_en_s),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i ({if_pc, if_instruction}),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (rd_data_s)
    );

    // Freeze comes only from the registered count, so id_ready never reaches IF combinationally
    assign if_freeze = (count_q == CNT_FULL);
    assign occupancy = count_q;

    // Handshake decode and head selection
    always_comb begin
        push_s = !if_freeze && !flush;
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass_s = (count_q == CNT_ZERO) && push_s && !rst;
`else
        bypass_s = 1'b0;
`endif
        id_valid  = ((count_q != CNT_ZERO) || bypass_s) && !flush;
        ram_pop_s = (count_q != CNT_ZERO) && !flush && id_ready;
        // A bypassed word taken by ID in the same cycle never occupies a slot
        wr_en_s   = push_s && !(bypass_s && id_ready);
        if (bypass_s) begin
            id_pc          = if_pc;
            id_instruction = if_instruction;
        end else begin
            id_pc          = rd_data_s[2*WORD_W-1:WORD_W];
            id_instruction = rd_data_s[WORD_W-1:0];
        end
    end

    // Pointer and count next-state; flush realigns rd_ptr to wr_ptr rather than to zero
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = CNT_ZERO;
        end else begin
            if (wr_en_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (ram_pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({wr_en_s, ram_pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Queue control registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= PTR_ZERO;
            rd_ptr_q <= PTR_ZERO;
            count_q  <= CNT_ZERO;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
